prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
Upstream boot stage for the miniRV core. It receives a program as a byte stream using a valid/ready handshake, for example from a UART receiver. It assembles little-endian 32-bit words and drives the core's rom_wen/rom_wdata/rom_addr write port. While loading, it holds the core in reset. Once the whole image is written, it releases the core so execution starts from BASE_ADDR.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first program word; must be 4-byte aligned.
MAX_WORDS, 16384, largest accepted program length in words (64 KiB ROM).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  in_data holds a valid byte
in_data  in  8  stream byte
in_ready  out  1  loader can accept a byte
start  in  1  one-cycle pulse; re-arms the loader from DONE or ERR
rom_wen  out  1  ROM write strobe (to core rom_wen)
rom_addr  out  32  ROM byte address, word aligned
rom_wdata  out  32  ROM write word
core_reset  out  1  active-high reset to the core; 1 while not DONE
done  out  1  image loaded successfully
err  out  1  load aborted

Behaviour:
- Reset values: state=HDR, in_ready=0, rom_wen=0, rom_addr=0, rom_wdata=0, core_reset=1, done=0, err=0, all counters 0.
- All outputs are registered.
- A byte is accepted in any cycle where in_valid && in_ready. Bytes are assembled little-endian: the first byte goes to bits [7:0].
- A 2-bit byte counter tracks bytes within the current word. A word index counter, width $clog2(MAX_WORDS+1), tracks words written.
- States:
  - HDR: in_ready=1. Collects 4 bytes forming the length L (words).
    - On the 4th byte: if L > MAX_WORDS go to ERR.
    - Else if L == 0 go to DONE (or CSUM when the feature is enabled).
    - Else go to DATA.
  - DATA: in_ready=1. On each 4th byte, the cycle after the handshake presents one write:
    - rom_wen=1 for exactly one cycle
    - rom_addr = BASE_ADDR + 4*idx (mod 2^32)
    - rom_wdata = the assembled word
    - idx then increments.
    - After word L is accepted, go to DONE (or CSUM).
    - The final write strobe still occurs in the cycle after that handshake.
  - DONE: in_ready=0, done=1, core_reset=0 from the first DONE cycle. The final rom_wen completes in the same cycle as core_reset falls.
  - ERR: in_ready=0, err=1, core_reset=1, no further writes.
- in_ready stays 1 through DATA, so the stream runs back-to-back at 1 byte per cycle. A new byte may be accepted in the same cycle as a write strobe.
- Gaps in in_valid stall assembly without losing state.
- start, when in DONE or ERR: next state HDR, counters cleared, done=0, err=0, core_reset=1.
- start in HDR/DATA/CSUM is ignored.
- Asserting reset mid-load aborts immediately. Partial words are discarded and words already written stay in ROM. After reset the loader re-enters HDR and expects a new header.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps a running 8-bit XOR of every payload byte (header excluded).
  - After the last payload word, state CSUM accepts one trailer byte.
  - If the trailer equals the running XOR, go to DONE; otherwise go to ERR.
  - The checksum register resets to 0 on reset and on start.
  - For L == 0 the expected trailer is 8'h00.
- Undefined: no CSUM state and no checksum logic. DATA goes directly to DONE.

Decomposition:
- Package prog_loader_pkg:
  - state enum (HDR, DATA, CSUM, DONE, ERR)
  - LEN_BYTES=4
  - localparam for the default MAX_WORDS
- One natural sub-module: byte_assembler.
  - Holds the byte counter and 32-bit shift register.
  - Pulses word_valid with the word on the 4th accepted byte.
  - Provides a clear input.
- The FSM, address generation and checksum stay in prog_loader.

Test Plan:
- Reset, then bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 at one per cycle -> rom_wen pulses twice: (addr 0x0, data 0x00100513) then (0x4, 0x00200593). done=1 and core_reset=0 in the cycle after the last write is presented.
- Same stream with in_valid toggled every other cycle -> identical writes and ordering; no extra rom_wen pulses.
- Header 00 00 00 00 -> no rom_wen; done=1 two cycles after the 4th header byte. Then a start pulse -> done=0, core_reset=1, in_ready=1.
- Header 01 40 00 00 (L=16385 > MAX_WORDS) -> err=1, in_ready=0, core_reset stays 1, no writes.
- Reset asserted after 2 payload bytes, released, full 1-word stream 01 00 00 00 EF BE AD DE -> single write (0x0, 0xDEADBEEF); the partial bytes do not leak into the word.
- LOADER_CHECKSUM_EN: 1-word stream 01 00 00 00 11 22 33 44 then trailer 44 -> done. Trailer 45 -> err=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-stage program loader.
// The state enum lists CSUM in every build; it is only reachable when LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

    localparam int          LEN_BYTES         = 4;
    localparam int          DEFAULT_MAX_WORDS = 16384;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Byte address of word idx; wraps modulo 2^32 like the core's address space.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready link feeding the loader (for example from a UART receiver).
interface prog_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/prog_loader_byte_assembler.sv
// Collects accepted stream bytes into little-endian 32-bit words.
// word/word_valid are presented in the same cycle as the 4th byte handshake.
module prog_loader_byte_assembler
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CNT_W = $clog2(LEN_BYTES);

    logic [CNT_W-1:0] byte_cnt;
    // Only the three earlier bytes are stored; the 4th is taken straight from the stream.
    logic [23:0]      shreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            shreg    <= {byte_in, shreg[23:8]};
        end
    end

    assign word_valid = accept && (byte_cnt == CNT_W'(LEN_BYTES - 1));
    assign word       = {byte_in, shreg};

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length header + payload words from a byte stream into the core ROM, core held in reset until done.
// Optional trailer checksum via macro LOADER_CHECKSUM_EN.
//
// state | meaning
// HDR   | collecting the 4-byte little-endian length (words)
// DATA  | collecting payload words, one ROM write per word
// CSUM  | waiting for the XOR trailer byte (LOADER_CHECKSUM_EN only)
// DONE  | image loaded, core released from reset
// ERR   | load aborted, core kept in reset
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    prog_loader_if.slave      strm,
    input  logic              start,
    output logic              rom_wen,
    output logic [31:0]       rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t PAYLOAD_END = CSUM;
`else
    localparam state_t PAYLOAD_END = DONE;
`endif

    state_t             state;
    state_t             next_state;
    logic               rearm;
    logic               accept;
    logic               asm_accept;
    logic               word_valid;
    logic [31:0]        word;
    logic               wr_word;
    logic               hdr_word;
    logic               last_word;

    logic               in_ready_q;
    logic               rom_wen_q;
    logic [31:0]        rom_addr_q;
    logic [31:0]        rom_wdata_q;
    logic               core_reset_q;
    logic               done_q;
    logic               err_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   len_q;

    // in_ready is only ever high in HDR/DATA/CSUM, so accept needs no extra state qualification.
    assign accept     = strm.in_valid && in_ready_q;
    assign asm_accept = accept && ((state == HDR) || (state == DATA));
    assign hdr_word   = (state == HDR) && word_valid;
    assign wr_word    = (state == DATA) && word_valid;
    assign last_word  = ((idx_q + IDX_W'(1)) == len_q);

    prog_loader_byte_assembler u_byte_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (rearm),
        .accept     (asm_accept),
        .byte_in    (strm.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (rearm) begin
            csum_q <= '0;
        end else if ((state == DATA) && accept) begin
            csum_q <= csum_q ^ strm.in_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HDR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        rearm      = 1'b0;
        case (state)
            HDR: begin
                if (word_valid) begin
                    if (word > 32'(MAX_WORDS)) begin
                        next_state = ERR;
                    end else if (word == 32'd0) begin
                        next_state = PAYLOAD_END;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid && last_word) begin
                    next_state = PAYLOAD_END;
                end
            end
            CSUM: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept) begin
                    next_state = (strm.in_data == csum_q) ? DONE : ERR;
                end
`else
                next_state = ERR;
`endif
            end
            DONE, ERR: begin
                if (start) begin
                    next_state = HDR;
                    rearm      = 1'b1;
                end
            end
            default: next_state = HDR;
        endcase
    end

    // Status outputs follow the state register one cycle later, except that a
    // re-arming start drops done/err and re-asserts core_reset immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready_q   <= 1'b0;
            rom_wen_q    <= 1'b0;
            rom_addr_q   <= '0;
            rom_wdata_q  <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            len_q        <= '0;
        end else begin
            in_ready_q   <= (next_state == HDR) || (next_state == DATA) || (next_state == CSUM);
            rom_wen_q    <= wr_word;
            done_q       <= (state == DONE) && !rearm;
            err_q        <= (state == ERR) && !rearm;
            core_reset_q <= !((state == DONE) && !rearm);
            if (wr_word) begin
                rom_addr_q  <= word_addr(BASE_ADDR, 32'(idx_q));
                rom_wdata_q <= word;
            end
            if (rearm) begin
                idx_q <= '0;
            end else if (wr_word) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if (hdr_word) begin
                len_q <= word[IDX_W-1:0];
            end
        end
    end

    assign strm.in_ready = in_ready_q;
    assign rom_wen       = rom_wen_q;
    assign rom_addr      = rom_addr_q;
    assign rom_wdata     = rom_wdata_q;
    assign core_reset    = core_reset_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected ROM writes are queued by the stimulus
// and popped by an independent monitor whenever rom_wen is seen.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        rom_wen;
    logic [31:0] rom_addr;
    logic [31:0] rom_wdata;
    logic        core_reset;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb_q[$];

    prog_loader_if strm ();

    always #5 clk = ~clk;

    prog_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (16384)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .strm       (strm),
        .start      (start),
        .rom_wen    (rom_wen),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Write monitor
    always @(negedge clk) begin
        if (reset === 1'b1 && rom_wen === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", rom_addr, rom_wdata);
            end else begin
                logic [63:0] exp;
                exp = sb_q.pop_front();
                if ({rom_addr, rom_wdata} !== exp) begin
                    n_fail++;
                    $display("FAIL rom_write: got addr %h data %h expected addr %h data %h",
                             rom_addr, rom_wdata, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        strm.in_valid = 1'b0;
        strm.in_data = 8'h00;
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        strm.in_valid = 1'b1;
        strm.in_data  = b;
        @(negedge clk);
        while (strm.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (strm.in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout: in_ready %b expected 1 for byte %h", strm.in_ready, b);
        end
        @(posedge clk);
        #1 strm.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$], input int gap);
        foreach (bytes[i]) send_byte(bytes[i], (i == bytes.size() - 1) ? 0 : gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
        sb_q.push_back({addr, data});
    endtask

    logic [7:0] prog2[$] = '{8'h02, 8'h00, 8'h00, 8'h00,
                             8'h13, 8'h05, 8'h10, 8'h00,
                             8'h93, 8'h05, 8'h20, 8'h00};

    initial begin
        // Reset values
        reset = 1'b0;
        strm.in_valid = 1'b0;
        strm.in_data = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_in_ready",   32'(strm.in_ready), 32'd0);
        check("rst_rom_wen",    32'(rom_wen),       32'd0);
        check("rst_rom_addr",   rom_addr,           32'd0);
        check("rst_rom_wdata",  rom_wdata,          32'd0);
        check("rst_core_reset", 32'(core_reset),    32'd1);
        check("rst_done",       32'(done),          32'd0);
        check("rst_err",        32'(err),           32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Two-word program, back to back
        expect_write(32'h0000_0000, 32'h0010_0513);
        expect_write(32'h0000_0004, 32'h0020_0593);
        send_bytes(prog2, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hB0, 0);
        @(negedge clk);
`else
        @(negedge clk);
        check("t1_last_wen", 32'(rom_wen), 32'd1);
`endif
        check("t1_done_early",   32'(done),          32'd0);
        check("t1_creset_early", 32'(core_reset),    32'd1);
        check("t1_ready_low",    32'(strm.in_ready), 32'd0);
        @(negedge clk);
        check("t1_done",   32'(done),       32'd1);
        check("t1_creset", 32'(core_reset), 32'd0);
        check("t1_err",    32'(err),        32'd0);
        repeat (3) @(negedge clk);
        check("t1_drained", 32'(sb_q.size()), 32'd0);

        // Same program with in_valid toggling
        do_reset();
        expect_write(32'h0000_0000, 32'h0010_0513);
        expect_write(32'h0000_0004, 32'h0020_0593);
        send_bytes(prog2, 1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hB0, 0);
`endif
        repeat (2) @(negedge clk);
        check("t2_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        check("t2_drained", 32'(sb_q.size()), 32'd0);

        // Zero-length image, then re-arm with start
        do_reset();
        send_bytes('{8'h00, 8'h00, 8'h00, 8'h00}, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        @(negedge clk);
        check("t3_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("t3_done",   32'(done),       32'd1);
        check("t3_creset", 32'(core_reset), 32'd0);
        pulse_start();
        @(negedge clk);
        check("t3_start_done",   32'(done),          32'd0);
        check("t3_start_creset", 32'(core_reset),    32'd1);
        check("t3_start_ready",  32'(strm.in_ready), 32'd1);

        // Oversized length header
        do_reset();
        send_bytes('{8'h01, 8'h40, 8'h00, 8'h00}, 0);
        @(negedge clk);
        check("t4_ready_low", 32'(strm.in_ready), 32'd0);
        @(negedge clk);
        check("t4_err",    32'(err),        32'd1);
        check("t4_creset", 32'(core_reset), 32'd1);
        check("t4_done",   32'(done),       32'd0);
        strm.in_valid = 1'b1;
        strm.in_data  = 8'h55;
        begin
            int seen_ready;
            seen_ready = 0;
            repeat (5) begin
                @(negedge clk);
                if (strm.in_ready === 1'b1) seen_ready++;
            end
            check("t4_ready_stays_low", 32'(seen_ready), 32'd0);
        end
        strm.in_valid = 1'b0;
        pulse_start();
        @(negedge clk);
        check("t4_start_err",   32'(err),           32'd0);
        check("t4_start_ready", 32'(strm.in_ready), 32'd1);

        // Reset mid-load, then a clean one-word image
        do_reset();
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB}, 0);
        do_reset();
        expect_write(32'h0000_0000, 32'hDEAD_BEEF);
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h22, 0);
`endif
        repeat (2) @(negedge clk);
        check("t5_done", 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        check("t5_drained", 32'(sb_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Matching trailer
        do_reset();
        expect_write(32'h0000_0000, 32'h4433_2211);
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}, 0);
        repeat (2) @(negedge clk);
        check("t6_done", 32'(done), 32'd1);
        check("t6_err",  32'(err),  32'd0);

        // Bad trailer
        do_reset();
        expect_write(32'h0000_0000, 32'h4433_2211);
        send_bytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45}, 0);
        repeat (2) @(negedge clk);
        check("t7_err",    32'(err),        32'd1);
        check("t7_done",   32'(done),       32'd0);
        check("t7_creset", 32'(core_reset), 32'd1);
        repeat (2) @(negedge clk);
        check("t7_drained", 32'(sb_q.size()), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
